// File: rtl/mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// mult_seq_pkg
//  Shared types and constants for the sequential 8x8 multiplier controller.
//  - state_t   : controller states (IDLE, PP0..PP3, DONE), 3-bit encoding
//  - nib_sel_t : which operand nibble feeds the 4x4 multiplier
//  - SHIFT_PPn : left shift applied to each partial product before it is
//                added into the accumulator
// -----------------------------------------------------------------------------
package mult_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PP0  = 3'd1,
        ST_PP1  = 3'd2,
        ST_PP2  = 3'd3,
        ST_PP3  = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    typedef enum logic {
        NIB_LO = 1'b0,
        NIB_HI = 1'b1
    } nib_sel_t;

    localparam logic [3:0] SHIFT_PP0 = 4'd0;
    localparam logic [3:0] SHIFT_PP1 = 4'd4;
    localparam logic [3:0] SHIFT_PP2 = 4'd4;
    localparam logic [3:0] SHIFT_PP3 = 4'd8;

endpackage

// File: rtl/mult4x4.sv
// -----------------------------------------------------------------------------
// mult4x4
//  Combinational 4x4 unsigned multiplier, the shared partial-product unit.
//  Ports:
//    a  in  4  multiplicand nibble
//    b  in  4  multiplier nibble
//    p  out 8  unsigned product a*b
// -----------------------------------------------------------------------------
module mult4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    assign p = {4'd0, a} * {4'd0, b};

endmodule

// File: rtl/mult8x8_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult8x8_seq_ctrl
//  Sequential 8x8 unsigned multiplier. One mult4x4 is time-shared over four
//  cycles; the operand nibbles are multiplexed into it and each shifted
//  partial product is accumulated into a 16-bit sum.
//
//  Parameters:
//    WIDTH       operand width (only 8 is supported with mult4x4)
//  Ports:
//    clk         rising-edge clock
//    reset       synchronous, active-high reset
//    start       request, sampled only in IDLE
//    dataa       multiplicand, captured on accepted start
//    datab       multiplier, captured on accepted start
//    product8x8  result, registered on the PP3 edge, held until the next one
//    done_flag   one-cycle pulse while the result is fresh
//    busy        high from the cycle after accept until DONE inclusive
//    err         sticky protocol error (start seen while not IDLE)
//
//  Configuration macro:
//    MULT_SEQ_ERR_EN  defined   -> err is a sticky protocol-error flag
//                     undefined -> err is tied to 0
// -----------------------------------------------------------------------------
module mult8x8_seq_ctrl
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   dataa,
    input  logic [WIDTH-1:0]   datab,
    output logic [2*WIDTH-1:0] product8x8,
    output logic               done_flag,
    output logic               busy,
    output logic               err
);

    localparam int HALF = WIDTH / 2;

    state_t             state, next_state;
    nib_sel_t           sel_a, sel_b;
    logic [3:0]         shift;
    logic [WIDTH-1:0]   aq, bq;
    logic [2*WIDTH-1:0] acc, acc_next, pp_shifted;
    logic [HALF-1:0]    nib_a, nib_b;
    logic [WIDTH-1:0]   p;

    wire accept = (state == ST_IDLE) && start;

    // -------------------------------------------------------------------------
    // Next-state and nibble/shift selection
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        next_state = state;
        sel_a      = NIB_LO;
        sel_b      = NIB_LO;
        shift      = SHIFT_PP0;
        case (state)
            ST_IDLE: if (start) next_state = ST_PP0;
            ST_PP0:  next_state = ST_PP1;
            ST_PP1: begin
                sel_a      = NIB_HI;
                shift      = SHIFT_PP1;
                next_state = ST_PP2;
            end
            ST_PP2: begin
                sel_b      = NIB_HI;
                shift      = SHIFT_PP2;
                next_state = ST_PP3;
            end
            ST_PP3: begin
                sel_a      = NIB_HI;
                sel_b      = NIB_HI;
                shift      = SHIFT_PP3;
                next_state = ST_DONE;
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Shared partial-product datapath
    // -------------------------------------------------------------------------
    assign nib_a = (sel_a == NIB_HI) ? aq[WIDTH-1:HALF] : aq[HALF-1:0];
    assign nib_b = (sel_b == NIB_HI) ? bq[WIDTH-1:HALF] : bq[HALF-1:0];

    mult4x4 u_mult4x4 (
        .a (nib_a),
        .b (nib_b),
        .p (p)
    );

    // Zero-extend to the accumulator width before shifting so no bits are lost.
    assign pp_shifted = {{WIDTH{1'b0}}, p} << shift;
    assign acc_next   = acc + pp_shifted;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // -------------------------------------------------------------------------
    // Operand capture, accumulation and result register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: operand and accumulator registers are reset too, so the
        // datapath never carries stale or X values into a fresh operation.
        if (reset) begin
            aq         <= '0;
            bq         <= '0;
            acc        <= '0;
            product8x8 <= '0;
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    aq  <= dataa;
                    bq  <= datab;
                    acc <= '0;
                end
                ST_PP0, ST_PP1, ST_PP2: acc <= acc_next;
                ST_PP3: begin
                    acc        <= acc_next;
                    product8x8 <= acc_next;
                end
                default: ;
            endcase
        end
    end

    assign done_flag = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    // -------------------------------------------------------------------------
    // Protocol error flag
    // -------------------------------------------------------------------------
`ifdef MULT_SEQ_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset)                             err_q <= 1'b0;
        else if (accept)                       err_q <= 1'b0;
        else if (start && (state != ST_IDLE))  err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
